timer_device: RTL and testbench
===============================

Name: timer_device

Overview:
- Memory-mapped timer peripheral on the device side of the system bridge.
- Responds to the word address, write enable and write data that the CPU-side bridge logic drives.
- Returns combinational read data and raises an interrupt line toward CP0.
- Holds three registers (CTRL, PRESET, COUNT) and runs a 4-state down-count machine supporting one-shot and auto-reload modes.

Parameters:
- BASE_ADDR, 32'h00007f00, byte base of the 16-byte register window; bits [3:0] must be 0.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- addr  input  30  word address (byte address [31:2]) from bridge.
- we  input  1  write enable from bridge, sampled at clk rising edge.
- wdata  input  32  write data.
- rdata  output  32  read data; combinational from addr and register state.
- irq  output  1  interrupt request to CP0.

Behaviour:
- Hit: addr[29:2] == BASE_ADDR[31:4]. Offset = addr[1:0]: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved.
- Writes take effect only when we=1 and hit. Writes to COUNT and reserved offsets are ignored.
- CTRL bit fields:
  - [0] EN: enable.
  - [2:1] MODE: 00 one-shot; any other value is auto-reload.
  - [3] IM: interrupt mask.
  - [31:4] always read 0; written values are discarded.
- Reads:
  - CTRL returns {28'b0, IM, MODE, EN}.
  - PRESET returns the full 32 bits.
  - COUNT returns count.
  - Reserved offset, or no hit, returns 32'h0.
- irq = IM & irq_flag (combinational).
- Reset (asynchronous, reset_n=0): CTRL=0, PRESET=0, count=0, irq_flag=0, state=IDLE. rdata therefore reads 0 and irq is 0. Reset asserted mid-count aborts immediately; no irq is produced.
- State machine (one transition per edge):
  - IDLE: if EN goes to LOAD, else stays in IDLE.
  - LOAD: count <= PRESET, then goes to CNT.
  - CNT:
    - If EN=0: goes to IDLE; count holds its value.
    - Else if count > 1: count <= count-1.
    - Else (count is 0 or 1): count <= 0, irq_flag <= 1, goes to INT.
  - INT:
    - MODE=00: EN <= 0, goes to IDLE; irq_flag stays 1.
    - Otherwise: irq_flag <= 0, goes to LOAD (reload); irq is a 1-cycle pulse.
- Latency: a write setting EN=1 with PRESET=P≥1, made at edge 0, gives irq=1 (with IM=1) after edge P+2. P=0 behaves as P=1 (irq after edge 3).
- irq_flag clear rules:
  - In one-shot mode it is cleared by any CTRL write or PRESET write (hit+we). Otherwise it holds.
  - A clear that occurs on the same edge as a set is overridden by the set.
- CTRL write vs FSM on the same edge: the CPU write wins. In INT with MODE=00, a simultaneous CTRL write of EN=1 leaves EN=1, and the FSM still goes to IDLE, then to LOAD on the next edge.
- PRESET write during CNT: the new value is stored immediately but used only at the next LOAD; the current count is unaffected.
- count is an unsigned 32-bit value and never wraps below 0.
- Clearing EN during LOAD: LOAD still completes, then CNT exits to IDLE on the next edge.

Test Plan:
- Reset: reset_n=0 mid-count with count=7 -> rdata at all offsets reads 0, irq=0, immediately and asynchronously.
- One-shot:
  - Stimulus: write PRESET=5, then CTRL=32'h9 (EN=1, MODE=00, IM=1).
  - Response: irq rises after edge 7 from the CTRL write, COUNT reads 0, CTRL reads 32'h8. irq stays 1 until a CTRL write of 32'h8, then falls the next cycle.
- Auto-reload:
  - Stimulus: PRESET=3, CTRL=32'hB.
  - Response: irq pulses 1 cycle wide, repeating every 5 cycles. COUNT sequence is 3,2,1,0, then reloads to 3.
- Mask and disable:
  - IM=0 with a one-shot run of PRESET=2 -> irq stays 0, yet irq_flag sets; a CTRL write of 32'h9 clears it.
  - EN cleared at COUNT=4 -> COUNT holds 4, no irq.
- Address decode:
  - Writes to 0x7f08, 0x7f0c and 0x7f10 -> no register changes.
  - Reads of 0x7f0c and 0x7f10 -> 0.
  - CTRL write of 32'hFFFFFFFF -> CTRL reads back 32'hF.
- Collision: PRESET write of 9 during CNT with count=6 -> the current run ends normally; the next reload (mode 01) loads 9.

Source files
------------

// File: rtl/timer_device_if.sv
// Bus bundle between the CPU-side bridge and the timer peripheral.
//   addr  : word address (byte address [31:2])
//   we    : write enable, sampled on the clock rising edge
//   wdata : write data
//   rdata : combinational read data from the peripheral
//   irq   : interrupt request toward CP0
interface timer_device_if;
  logic [29:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output addr,
    output we,
    output wdata,
    input  rdata,
    input  irq
  );

  modport slave (
    input  addr,
    input  we,
    input  wdata,
    output rdata,
    output irq
  );
endinterface

// File: rtl/timer_device.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// Ports:
//   clk     : system clock, state updates on rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of timer_device_if (addr/we/wdata in, rdata/irq out)
// Register window (word offsets from BASE_ADDR): 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved.
module timer_device #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
) (
  input logic           clk,
  input logic           reset_n,
  timer_device_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StCnt  = 2'd2;
  localparam logic [1:0] StInt  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;

  logic hit;
  logic wr_ctrl;
  logic wr_preset;
  logic one_shot;

  assign hit       = (bus.addr[29:2] == BASE_ADDR[31:4]);
  assign wr_ctrl   = bus.we && hit && (bus.addr[1:0] == 2'd0);
  assign wr_preset = bus.we && hit && (bus.addr[1:0] == 2'd1);
  assign one_shot  = (mode_q == 2'b00);

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    // Any CTRL/PRESET access acknowledges a latched one-shot interrupt. The FSM
    // below runs afterwards so a set on the same edge overrides this clear.
    if (one_shot && (wr_ctrl || wr_preset)) begin
      flag_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (en_q) state_d = StLoad;
      end
      StLoad: begin
        count_d = preset_q;
        state_d = StCnt;
      end
      StCnt: begin
        if (!en_q) begin
          state_d = StIdle;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // A preset of 0 terminates like a preset of 1; count never wraps.
          count_d = 32'd0;
          flag_d  = 1'b1;
          state_d = StInt;
        end
      end
      StInt: begin
        if (one_shot) begin
          en_d    = 1'b0;
          state_d = StIdle;
        end else begin
          flag_d  = 1'b0;
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase

    // CPU writes take priority over the FSM's own EN update.
    if (wr_ctrl) begin
      en_d   = bus.wdata[0];
      mode_d = bus.wdata[2:1];
      im_d   = bus.wdata[3];
    end
    if (wr_preset) begin
      preset_d = bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      en_q     <= 1'b0;
      mode_q   <= 2'b00;
      im_q     <= 1'b0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    bus.rdata = 32'd0;
    if (hit) begin
      unique case (bus.addr[1:0])
        2'd0:    bus.rdata = {28'd0, im_q, mode_q, en_q};
        2'd1:    bus.rdata = preset_q;
        2'd2:    bus.rdata = count_q;
        default: bus.rdata = 32'd0;
      endcase
    end
  end

  assign bus.irq = im_q & flag_q;

endmodule

// File: tb/tb_timer_device.sv
module tb_timer_device;
  localparam logic [31:0] Base   = 32'h0000_7f00;
  localparam logic [31:0] ACtrl  = 32'h0000_7f00;
  localparam logic [31:0] APre   = 32'h0000_7f04;
  localparam logic [31:0] ACount = 32'h0000_7f08;
  localparam logic [31:0] ARes   = 32'h0000_7f0c;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  timer_device_if bus ();

  timer_device #(.BASE_ADDR(Base)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Behavioural reference model, advanced once per clock edge by tick().
  bit          m_en, m_im, m_flag;
  logic [1:0]  m_mode;
  logic [31:0] m_preset, m_count;
  string       m_phase;

  task automatic model_reset();
    m_en = 0; m_im = 0; m_flag = 0; m_mode = 2'b00;
    m_preset = 0; m_count = 0; m_phase = "IDLE";
  endtask

  task automatic model_step();
    logic [31:0] b;
    bit hit, wc, wp, n_en, n_flag;
    logic [31:0] n_count;
    string n_phase;
    if (!reset_n) begin
      model_reset();
      return;
    end
    b   = {bus.addr, 2'b00};
    hit = ((b & 32'hFFFF_FFF0) == Base);
    wc  = bus.we && hit && ((b % 16) == 0);
    wp  = bus.we && hit && ((b % 16) == 4);
    n_en = m_en; n_flag = m_flag; n_count = m_count; n_phase = m_phase;
    if (m_mode == 0 && (wc || wp)) n_flag = 0;
    if (m_phase == "IDLE") begin
      if (m_en) n_phase = "LOAD";
    end else if (m_phase == "LOAD") begin
      n_count = m_preset; n_phase = "CNT";
    end else if (m_phase == "CNT") begin
      if (!m_en) n_phase = "IDLE";
      else if (m_count > 1) n_count = m_count - 1;
      else begin n_count = 0; n_flag = 1; n_phase = "INT"; end
    end else begin
      if (m_mode == 0) begin n_en = 0; n_phase = "IDLE"; end
      else begin n_flag = 0; n_phase = "LOAD"; end
    end
    if (wc) begin
      n_en = bus.wdata[0]; m_mode = bus.wdata[2:1]; m_im = bus.wdata[3];
    end
    if (wp) m_preset = bus.wdata;
    m_en = n_en; m_flag = n_flag; m_count = n_count; m_phase = n_phase;
  endtask

  function automatic logic [31:0] model_read(input logic [29:0] a);
    logic [31:0] b;
    b = {a, 2'b00};
    if ((b & 32'hFFFF_FFF0) != Base) return 32'd0;
    if ((b % 16) == 0) return {28'd0, m_im, m_mode, m_en};
    if ((b % 16) == 4) return m_preset;
    if ((b % 16) == 8) return m_count;
    return 32'd0;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] ba, input logic [31:0] d);
    bus.addr  = ba[31:2];
    bus.wdata = d;
    bus.we    = 1'b1;
    tick();
    bus.we    = 1'b0;
  endtask

  task automatic rd(input logic [31:0] ba, output logic [31:0] d);
    bus.addr = ba[31:2];
    bus.we   = 1'b0;
    #1;
    d = bus.rdata;
  endtask

  task automatic do_reset();
    bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    reset_n = 1'b0;
    model_reset();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bit found;
    do_reset();
    rd(ACtrl, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl got %h want 0", d); end
    rd(APre, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_preset got %h want 0", d); end
    n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", bus.irq); end
    // Abort mid-count with count=7.
    wr(APre, 32'd10);
    wr(ACtrl, 32'h9);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      rd(ACount, d);
      if (d == 32'd7) found = 1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL reset_reach7 got %h want 7", d); end
    #3;
    reset_n = 1'b0;
    model_reset();
    for (int o = 0; o < 4; o++) begin
      rd(Base + 32'(o * 4), d);
      n_checks++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL reset_async_off%0d got %h want 0", o, d); end
    end
    n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL reset_async_irq got %b want 0", bus.irq); end
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    rd(ACount, d);
    n_checks++;
    if (d !== 32'd0 || bus.irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_abort count %h irq %b want 0 0", d, bus.irq);
    end
  endtask

  task automatic test_one_shot();
    logic [31:0] d;
    do_reset();
    wr(APre, 32'd5);
    wr(ACtrl, 32'h9);
    for (int k = 1; k <= 7; k++) begin
      tick();
      n_checks++;
      if (bus.irq !== (k == 7)) begin
        n_fail++; $display("FAIL oneshot_irq edge %0d got %b want %b", k, bus.irq, k == 7);
      end
    end
    rd(ACount, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL oneshot_count got %h want 0", d); end
    for (int k = 0; k < 3; k++) tick();
    rd(ACtrl, d);
    n_checks++; if (d !== 32'h8) begin n_fail++; $display("FAIL oneshot_ctrl got %h want 8", d); end
    n_checks++; if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL oneshot_hold got %b want 1", bus.irq); end
    wr(ACtrl, 32'h8);
    n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_clear got %b want 0", bus.irq); end
  endtask

  task automatic test_auto_reload();
    logic [31:0] d, exp_c;
    int p;
    do_reset();
    wr(APre, 32'd3);
    wr(ACtrl, 32'hB);
    for (int k = 1; k <= 21; k++) begin
      tick();
      rd(ACount, d);
      p = (k - 2) % 5;
      if (k < 2) exp_c = 0;
      else exp_c = (p <= 2) ? 32'(3 - p) : 32'd0;
      n_checks++;
      if (d !== exp_c) begin n_fail++; $display("FAIL reload_count edge %0d got %0d want %0d", k, d, exp_c); end
      n_checks++;
      if (bus.irq !== (k >= 5 && (k - 5) % 5 == 0)) begin
        n_fail++; $display("FAIL reload_irq edge %0d got %b", k, bus.irq);
      end
    end
  endtask

  task automatic test_mask_disable();
    logic [31:0] d;
    bit found;
    do_reset();
    wr(APre, 32'd2);
    wr(ACtrl, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL mask_irq edge %0d got %b want 0", k, bus.irq); end
    end
    // Unmasking via this write must also clear the hidden latched flag.
    wr(ACtrl, 32'h9);
    n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL mask_unmask got %b want 0", bus.irq); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_checks++;
      if (bus.irq !== (k == 4)) begin n_fail++; $display("FAIL mask_rerun edge %0d got %b", k, bus.irq); end
    end
    do_reset();
    wr(APre, 32'd10);
    wr(ACtrl, 32'h9);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      rd(ACount, d);
      if (d == 32'd5) found = 1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL disable_reach5 got %h want 5", d); end
    wr(ACtrl, 32'h8);
    for (int k = 0; k < 15; k++) begin
      tick();
      n_checks++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL disable_irq got %b want 0", bus.irq); end
    end
    rd(ACount, d);
    n_checks++; if (d !== 32'd4) begin n_fail++; $display("FAIL disable_hold got %0d want 4", d); end
  endtask

  task automatic test_addr_decode();
    logic [31:0] d;
    do_reset();
    wr(ACount, 32'h1234);
    wr(ARes, 32'hFF);
    wr(32'h7f10, 32'h9);
    wr(32'h7f14, 32'h55);
    for (int k = 0; k < 3; k++) tick();
    rd(ACtrl, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL decode_ctrl got %h want 0", d); end
    rd(APre, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL decode_preset got %h want 0", d); end
    rd(ACount, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL decode_count got %h want 0", d); end
    wr(APre, 32'h77);
    rd(APre, d);
    n_checks++; if (d !== 32'h77) begin n_fail++; $display("FAIL decode_pre_rb got %h want 77", d); end
    rd(ARes, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL decode_rd_7f0c got %h want 0", d); end
    rd(32'h7f10, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL decode_rd_7f10 got %h want 0", d); end
    rd(32'h7f14, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL decode_rd_7f14 got %h want 0", d); end
    wr(ACtrl, 32'hFFFF_FFFF);
    rd(ACtrl, d);
    n_checks++; if (d !== 32'hF) begin n_fail++; $display("FAIL decode_ctrl_mask got %h want f", d); end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    bit found;
    do_reset();
    wr(APre, 32'd8);
    wr(ACtrl, 32'hB);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      rd(ACount, d);
      if (d == 32'd6) found = 1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL coll_reach6 got %h want 6", d); end
    wr(APre, 32'd9);
    rd(ACount, d);
    n_checks++; if (d !== 32'd5) begin n_fail++; $display("FAIL coll_count got %0d want 5", d); end
    rd(APre, d);
    n_checks++; if (d !== 32'd9) begin n_fail++; $display("FAIL coll_preset got %0d want 9", d); end
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.irq === 1'b1) found = 1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL coll_irq got %b want 1", bus.irq); end
    tick();
    tick();
    rd(ACount, d);
    n_checks++; if (d !== 32'd9) begin n_fail++; $display("FAIL coll_reload got %0d want 9", d); end
  endtask

  task automatic test_random();
    logic [31:0] addrs [6] = '{32'h7f00, 32'h7f04, 32'h7f08, 32'h7f0c, 32'h7f10, 32'h3f00};
    logic [31:0] d, exp_d;
    int r;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 1) wr(ACtrl, $urandom | 32'(r == 0));
      else if (r == 2) wr(APre, 32'($urandom_range(0, 6)));
      else if (r == 3) wr(addrs[$urandom_range(0, 5)], $urandom);
      else tick();
      rd(addrs[$urandom_range(0, 5)], d);
      exp_d = model_read(bus.addr);
      n_checks++;
      if (d !== exp_d) begin
        n_fail++; $display("FAIL rand_rdata iter %0d addr %h got %h want %h", i, {bus.addr, 2'b00}, d, exp_d);
      end
      n_checks++;
      if (bus.irq !== (m_im & m_flag)) begin
        n_fail++; $display("FAIL rand_irq iter %0d got %b want %b", i, bus.irq, m_im & m_flag);
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    model_reset();
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_mask_disable();
    test_addr_decode();
    test_collision();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
